rr_arb4: RTL and testbench
==========================

RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 12, giving the data width of every channel.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 4 bits: bit i means channel i presents data.
REQ-005 The block SHALL have ports in_data0, in_data1, in_data2 and in_data3, input, WIDTH bits each: channel payloads.
REQ-006 The block SHALL have port in_ready, output, 4 bits: bit i means channel i's transfer is accepted this cycle.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the output register holds a word.
REQ-008 The block SHALL have port out_data, output, WIDTH bits: the registered payload.
REQ-009 The block SHALL have port out_sel, output, 2 bits: the registered source channel index, suitable as a downstream 4:1 mux select.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts out_data this cycle.

Function
REQ-011 An input transfer SHALL occur on channel i when in_valid[i] and in_ready[i] are both 1 at a rising clk edge.
REQ-012 An output transfer SHALL occur when out_valid and out_ready are both 1 at a rising clk edge.
REQ-013 The block SHALL compute load_en = !out_valid | out_ready combinationally; a combinational path out_ready -> in_ready is permitted.
REQ-014 Priority SHALL rotate: the search starts at (last_grant+1) mod 4 and increments mod 4; the first channel found with in_valid=1 is the grant g.
REQ-015 in_ready SHALL be one-hot at g when load_en=1 and any in_valid is 1; otherwise in_ready SHALL be 4'b0000.
REQ-016 On an input transfer, the block SHALL register out_data <= in_data<g>, out_sel <= g, last_grant <= g and out_valid <= 1 at the same edge.
REQ-017 When load_en=1 and in_valid=0, out_valid SHALL become 0 at the edge, while out_data and out_sel hold their values.
REQ-018 When out_valid=1 and out_ready=0, out_data, out_sel, out_valid and last_grant SHALL all hold, and in_ready SHALL be 0.
REQ-019 A simultaneous output transfer and input transfer SHALL replace the word in one edge with no bubble, sustaining one word per cycle.
REQ-020 Latency SHALL be exactly 1 cycle from the input transfer edge to out_valid=1 carrying that word.
REQ-021 in_valid, in_data and out_ready are not registered inside the block; arbitration SHALL use their current-cycle values only.
REQ-022 last_grant SHALL change only on an input transfer; idle cycles SHALL NOT advance priority.
REQ-023 With all four channels continuously valid and out_ready=1, grants SHALL follow the order 0,1,2,3,0,... and no channel SHALL wait more than 3 grants.

Reset
REQ-024 While reset=1, regardless of clk, the block SHALL force out_valid=0, out_data=0, out_sel=0 and last_grant=3, so channel 0 has first priority.
REQ-025 While reset=1, in_ready SHALL be 4'b0000.
REQ-026 A reset asserted mid-stream SHALL discard any held output word, with no partial transfer on the reset edge.
REQ-027 The first input transfer SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-028 Reset then in_valid=4'b1111 with in_data0..3=0x100/0x201/0x302/0x403 and out_ready=1 -> out_sel sequence 0,1,2,3,0 with matching out_data, one word per cycle.
REQ-029 Only channel 2 valid with data 0xABC for 3 cycles, out_ready=1 -> three words 0xABC with out_sel=2 and in_ready=4'b0100 each cycle.
REQ-030 Word loaded with out_ready=0 for 5 cycles while in_valid=4'b1111 -> out_data and out_sel stable, in_ready=0; on out_ready=1 -> next grant is last_grant+1.
REQ-031 last_grant=1, then in_valid=4'b0001 -> grant 0; then in_valid=4'b0011 -> grant 1 (rotation from 0).
REQ-032 Reset pulse asserted asynchronously between edges while out_valid=1 -> out_valid=0, out_data=0x000 and out_sel=0 immediately; after release with in_valid=4'b1010 -> grant 1.
REQ-033 in_valid=0 with out_ready=1 after a word -> out_valid=0 at the next edge, out_data retains its last value.

Source files
------------

// File: rtl/rr_arb4.sv
// Four-channel round-robin arbiter feeding a single registered output slot.
// Priority rotates from the channel after the last one granted.
module rr_arb4 #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_sel,
  input  logic             out_ready
);

  logic [3:0][WIDTH-1:0] data;
  logic [1:0]            last_grant;
  logic [1:0]            grant;
  logic [1:0]            idx;
  logic                  found;
  logic                  any_valid;
  logic                  load_en;

  assign data      = {in_data3, in_data2, in_data1, in_data0};
  assign any_valid = |in_valid;
  // The slot can take a new word when it is empty or being drained this cycle.
  assign load_en   = !out_valid | out_ready;

  always_comb begin
    grant = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k < 5; k++) begin
      idx = last_grant + 2'(k);
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign in_ready = (!reset && load_en && any_valid) ? (4'b0001 << grant) : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= 2'd3;
    end else if (load_en) begin
      if (any_valid) begin
        out_valid  <= 1'b1;
        out_data   <= data[grant];
        out_sel    <= grant;
        last_grant <= grant;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb4.sv
// Bench for rr_arb4: a rotating-priority reference model checked every cycle,
// plus directed sequences with literal expected values.
module tb_rr_arb4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [11:0] in_data0, in_data1, in_data2, in_data3;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [11:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int n_cmp = 0;
  int n_err = 0;

  rr_arb4 #(.WIDTH(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: output slot contents plus the last channel served.
  logic        m_valid;
  logic [11:0] m_data;
  int          m_sel;
  int          m_last;

  function automatic int pick(input int last, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [11:0] data_of(input int c);
    case (c)
      0: return in_data0;
      1: return in_data1;
      2: return in_data2;
      default: return in_data3;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= 12'h000;
      m_sel   <= 0;
      m_last  <= 3;
    end else if (!m_valid || out_ready) begin
      if (pick(m_last, in_valid) >= 0) begin
        m_valid <= 1'b1;
        m_data  <= data_of(pick(m_last, in_valid));
        m_sel   <= pick(m_last, in_valid);
        m_last  <= pick(m_last, in_valid);
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // Every negedge: outputs and the combinational ready against the model.
  always @(negedge clk) begin
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0000;
    if (!reset && (!m_valid || out_ready) && pick(m_last, in_valid) >= 0)
      exp_rdy[pick(m_last, in_valid)] = 1'b1;
    chk("model_in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("model_out_valid", 32'(out_valid), 32'(m_valid));
    chk("model_out_data", 32'(out_data), 32'(m_data));
    chk("model_out_sel", 32'(out_sel), 32'(m_sel));
  end

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 4'b1111;
    in_data0  = 12'h100;
    in_data1  = 12'h201;
    in_data2  = 12'h302;
    in_data3  = 12'h403;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // All four valid: strict 0,1,2,3,0 rotation, one word per cycle.
    for (int k = 0; k < 5; k++) begin
      after_edge();
      chk("rot_sel", 32'(out_sel), 32'(k % 4));
      chk("rot_data", 32'(out_data), 32'(12'h100 + 12'(k % 4) * 12'h101));
      chk("rot_valid", 32'(out_valid), 32'd1);
    end

    // Only channel 2 valid.
    in_valid = 4'b0100;
    in_data2 = 12'hABC;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ch2_in_ready", 32'(in_ready), 32'h4);
      after_edge();
      chk("ch2_sel", 32'(out_sel), 32'd2);
      chk("ch2_data", 32'(out_data), 32'hABC);
    end

    // Idle drains the slot but the data register keeps its value.
    in_valid = 4'b0000;
    after_edge();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_data", 32'(out_data), 32'hABC);

    // Backpressure: load once (grant 3 after last grant 2), then hold.
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    after_edge();
    chk("bp_load_sel", 32'(out_sel), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      after_edge();
      chk("bp_sel", 32'(out_sel), 32'd3);
      chk("bp_data", 32'(out_data), 32'h403);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'h1);
    after_edge();
    chk("bp_release_sel", 32'(out_sel), 32'd0);

    // Rotation from last grant 1 with sparse requests.
    in_valid = 4'b0010;
    after_edge();
    chk("sparse_g1", 32'(out_sel), 32'd1);
    in_valid = 4'b0001;
    after_edge();
    chk("sparse_g0", 32'(out_sel), 32'd0);
    in_valid = 4'b0011;
    after_edge();
    chk("sparse_g1b", 32'(out_sel), 32'd1);
    chk("sparse_g1b_data", 32'(out_data), 32'h201);

    // Asynchronous reset between edges while holding a word.
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_sel", 32'(out_sel), 32'd0);
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    #0;
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    #1;
    reset = 1'b0;
    after_edge();
    chk("post_rst_sel", 32'(out_sel), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h201);
    after_edge();
    chk("post_rst_sel2", 32'(out_sel), 32'd3);

    in_valid = 4'b0000;
    repeat (2) after_edge();
    chk("final_idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
